// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, debug-loader and data-memory signals of the dm_arbiter
interface dm_arbiter_if;
  // CPU load/store port
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_sb;
  logic        cpu_sh;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_err;
  logic        cpu_stall;
  // Debug loader port (word accesses only)
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;
  logic        dbg_err;
  // Shared data-memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_sb, cpu_sh, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack, dbg_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  // Requester / memory side
  modport master (
    output cpu_req, cpu_we, cpu_sb, cpu_sh, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack, dbg_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin CPU/debug data-memory arbiter with store lane steering and watchdog
module dm_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_CPU = 2'd1,
    BUSY_DBG = 2'd2
  } state_t;

  localparam logic       GRANT_CPU = 1'b0;
  localparam logic       GRANT_DBG = 1'b1;
  localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

  state_t      r_state;
  logic        r_last_grant;
  logic [7:0]  r_cnt;

  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        r_cpu_ack;
  logic        r_cpu_err;
  logic [31:0] r_cpu_rdata;
  logic        r_dbg_ack;
  logic        r_dbg_err;
  logic [31:0] r_dbg_rdata;

  logic [3:0]  w_cpu_be;
  logic [31:0] w_cpu_wdata;
  logic        w_cpu_misaligned;
  logic        w_cpu_elig;
  logic        w_dbg_elig;
  logic        w_pick_cpu;
  logic        w_pick_dbg;
  logic        w_timeout;
  logic        w_unused;

  // Debug accesses are always word-aligned; the low address bits carry no meaning.
  assign w_unused = ^bus.dbg_addr[1:0];

  // CPU store steering: replicate the byte/half across lanes and flag misaligned writes.
  always_comb begin
    w_cpu_be         = 4'b1111;
    w_cpu_wdata      = bus.cpu_wdata;
    w_cpu_misaligned = 1'b0;
    if (bus.cpu_we) begin
      if (bus.cpu_sb) begin
        w_cpu_be    = 4'b0001 << bus.cpu_addr[1:0];
        w_cpu_wdata = {4{bus.cpu_wdata[7:0]}};
      end else if (bus.cpu_sh) begin
        w_cpu_be         = bus.cpu_addr[1] ? 4'b1100 : 4'b0011;
        w_cpu_wdata      = {2{bus.cpu_wdata[15:0]}};
        w_cpu_misaligned = bus.cpu_addr[0];
      end else begin
        w_cpu_misaligned = |bus.cpu_addr[1:0];
      end
    end
  end

  // A port acknowledged this cycle still has its old request up, so it sits out this round.
  assign w_cpu_elig = bus.cpu_req & ~r_cpu_ack;
  assign w_dbg_elig = bus.dbg_req & ~r_dbg_ack;
  assign w_pick_cpu = w_cpu_elig & (~w_dbg_elig | (r_last_grant == GRANT_DBG));
  assign w_pick_dbg = w_dbg_elig & ~w_pick_cpu;
  assign w_timeout  = (r_cnt + 8'd1) == TIMEOUT_8;

  // Arbitration, transaction sequencing, watchdog and completion reporting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_DBG;
      r_cnt        <= 8'd0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_be     <= 4'd0;
      r_cpu_ack    <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_cpu_rdata  <= 32'd0;
      r_dbg_ack    <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_dbg_rdata  <= 32'd0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_cpu_err <= 1'b0;
      r_dbg_ack <= 1'b0;
      r_dbg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_cpu) begin
            r_last_grant <= GRANT_CPU;
            r_cnt        <= 8'd0;
            r_mem_we     <= bus.cpu_we;
            r_mem_addr   <= {bus.cpu_addr[31:2], 2'b00};
            r_mem_be     <= w_cpu_be;
            r_mem_wdata  <= w_cpu_wdata;
            if (w_cpu_misaligned) begin
              // Rejected without touching memory; error reported next cycle.
              r_cpu_ack   <= 1'b1;
              r_cpu_err   <= 1'b1;
              r_cpu_rdata <= 32'd0;
            end else begin
              r_state <= BUSY_CPU;
            end
          end else if (w_pick_dbg) begin
            r_last_grant <= GRANT_DBG;
            r_cnt        <= 8'd0;
            r_mem_we     <= bus.dbg_we;
            r_mem_addr   <= {bus.dbg_addr[31:2], 2'b00};
            r_mem_be     <= 4'b1111;
            r_mem_wdata  <= bus.dbg_wdata;
            r_state      <= BUSY_DBG;
          end
        end
        BUSY_CPU, BUSY_DBG: begin
          // A memory ack in the watchdog's last cycle still counts as a normal completion.
          if (bus.mem_ack) begin
            r_state <= IDLE;
            if (r_state == BUSY_CPU) begin
              r_cpu_ack   <= 1'b1;
              r_cpu_rdata <= bus.mem_rdata;
            end else begin
              r_dbg_ack   <= 1'b1;
              r_dbg_rdata <= bus.mem_rdata;
            end
          end else if (w_timeout) begin
            r_state <= IDLE;
            if (r_state == BUSY_CPU) begin
              r_cpu_ack   <= 1'b1;
              r_cpu_err   <= 1'b1;
              r_cpu_rdata <= 32'd0;
            end else begin
              r_dbg_ack   <= 1'b1;
              r_dbg_err   <= 1'b1;
              r_dbg_rdata <= 32'd0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;

  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.cpu_err   = r_cpu_err;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;

  assign bus.dbg_ack   = r_dbg_ack;
  assign bus.dbg_err   = r_dbg_err;
  assign bus.dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - directed scoreboard bench for dm_arbiter
module tb_dm_arbiter;

  logic clk;
  logic rst;

  dm_arbiter_if bus();

  dm_arbiter #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_dbg;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_lat = 0;
  int          busy_cnt = 0;
  logic [31:0] mem_data = 32'd0;
  logic        auto_drop = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_dbg, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.is_dbg = is_dbg;
    e.err    = err;
    e.rdata  = rdata;
    sb_q.push_back(e);
  endtask

  task automatic take_ack(input logic is_dbg, input logic err, input logic [31:0] rdata);
    exp_t e;
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL ack_unexpected: observed ack on port %0d expected none", is_dbg);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("ack_port_err_rdata", {30'd0, is_dbg, err, rdata}, {30'd0, e.is_dbg, e.err, e.rdata});
    end
    if (auto_drop) begin
      if (is_dbg) bus.dbg_req = 1'b0;
      else        bus.cpu_req = 1'b0;
    end
  endtask

  // One clock: sample just after the edge, feed the scoreboard, then play the memory.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus.cpu_ack) take_ack(1'b0, bus.cpu_err, bus.cpu_rdata);
    if (bus.dbg_ack) take_ack(1'b1, bus.dbg_err, bus.dbg_rdata);
    if (bus.mem_req) busy_cnt++;
    else             busy_cnt = 0;
    bus.mem_ack   = bus.mem_req && (mem_lat != 0) && (busy_cnt == mem_lat);
    bus.mem_rdata = mem_data;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   {63'd0, bus.mem_req},   64'd0);
    check({tag, "_mem_we"},    {63'd0, bus.mem_we},    64'd0);
    check({tag, "_mem_be"},    {60'd0, bus.mem_be},    64'd0);
    check({tag, "_mem_addr"},  {32'd0, bus.mem_addr},  64'd0);
    check({tag, "_mem_wdata"}, {32'd0, bus.mem_wdata}, 64'd0);
    check({tag, "_acks_errs"}, {60'd0, bus.cpu_ack, bus.dbg_ack, bus.cpu_err, bus.dbg_err}, 64'd0);
    check({tag, "_cpu_rdata"}, {32'd0, bus.cpu_rdata}, 64'd0);
    check({tag, "_dbg_rdata"}, {32'd0, bus.dbg_rdata}, 64'd0);
  endtask

  initial begin
    int   req_cycles;
    logic got;

    rst           = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_sb    = 1'b0;
    bus.cpu_sh    = 1'b0;
    bus.cpu_addr  = 32'd0;
    bus.cpu_wdata = 32'd0;
    bus.dbg_req   = 1'b0;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 32'd0;
    bus.dbg_wdata = 32'd0;
    bus.mem_rdata = 32'd0;
    bus.mem_ack   = 1'b0;

    // Reset state
    cycle();
    cycle();
    check_reset_outputs("reset");
    rst = 1'b1;
    cycle();

    // Test 1: CPU store byte at 0x1003, memory acks in the third request cycle
    mem_lat = 3; mem_data = 32'd0; auto_drop = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_sb = 1'b1; bus.cpu_sh = 1'b0;
    bus.cpu_addr = 32'h0000_1003; bus.cpu_wdata = 32'h0000_00A5;
    push_exp(1'b0, 1'b0, 32'd0);
    cycle();
    check("sb_mem_req",   {63'd0, bus.mem_req},   64'd1);
    check("sb_mem_we",    {63'd0, bus.mem_we},    64'd1);
    check("sb_mem_be",    {60'd0, bus.mem_be},    64'h8);
    check("sb_mem_wdata", {32'd0, bus.mem_wdata}, 64'hA5A5_A5A5);
    check("sb_mem_addr",  {32'd0, bus.mem_addr},  64'h1000);
    check("sb_stall",     {63'd0, bus.cpu_stall}, 64'd1);
    cycle();
    cycle();
    check("sb_mem_ack_now", {63'd0, bus.mem_ack}, 64'd1);
    check("sb_no_ack_yet",  {63'd0, bus.cpu_ack}, 64'd0);
    cycle();
    check("sb_ack_next",   {63'd0, bus.cpu_ack}, 64'd1);
    check("sb_req_dropped", {63'd0, bus.mem_req}, 64'd0);
    cycle();
    bus.cpu_sb = 1'b0; bus.cpu_we = 1'b0;

    // Test 2: both requesters held from reset, grants must alternate CPU/DBG
    auto_drop = 1'b0; mem_lat = 1; mem_data = 32'h1111_2222;
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0100;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0000_0200;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 1'b0, 32'h1111_2222);
      push_exp(1'b1, 1'b0, 32'h1111_2222);
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (sb_q.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    bus.cpu_req = 1'b0; bus.dbg_req = 1'b0;
    check("rr_all_grants_seen", {63'd0, got}, 64'd1);
    cycle();
    cycle();
    auto_drop = 1'b1;

    // Test 3: misaligned CPU store half at 0x2001
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_sh = 1'b1; bus.cpu_sb = 1'b0;
    bus.cpu_addr = 32'h0000_2001; bus.cpu_wdata = 32'h0000_BEEF;
    push_exp(1'b0, 1'b1, 32'd0);
    cycle();
    check("mis_ack",    {63'd0, bus.cpu_ack}, 64'd1);
    check("mis_no_mem", {63'd0, bus.mem_req}, 64'd0);
    cycle();
    check("mis_ack_pulse", {63'd0, bus.cpu_ack}, 64'd0);
    check("mis_no_mem2",   {63'd0, bus.mem_req}, 64'd0);
    bus.cpu_sh = 1'b0; bus.cpu_we = 1'b0;

    // Test 4: debug read that memory never acknowledges -> watchdog abort after 4 cycles
    mem_lat = 0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0000_0300;
    push_exp(1'b1, 1'b1, 32'd0);
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.mem_req) req_cycles++;
      if (bus.dbg_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("to_ack_seen",   {63'd0, got}, 64'd1);
    check("to_req_cycles", 64'(req_cycles), 64'd4);
    check("to_req_low",    {63'd0, bus.mem_req}, 64'd0);
    check("to_rdata",      {32'd0, bus.dbg_rdata}, 64'd0);
    cycle();

    // Test 5: CPU read, then reset in the middle of a debug transaction
    mem_lat = 2; mem_data = 32'hDEAD_BEEF;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0400;
    push_exp(1'b0, 1'b0, 32'hDEAD_BEEF);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.cpu_ack) begin
        got = 1'b1;
        break;
      end
    end
    check("rd_ack_seen", {63'd0, got}, 64'd1);
    check("rd_rdata",    {32'd0, bus.cpu_rdata}, 64'hDEAD_BEEF);
    cycle();
    check("rd_rdata_hold", {32'd0, bus.cpu_rdata}, 64'hDEAD_BEEF);
    mem_lat = 0;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0000_0500;
    cycle();
    check("rst_busy_dbg", {63'd0, bus.mem_req}, 64'd1);
    check("rst_busy_addr", {32'd0, bus.mem_addr}, 64'h500);
    cycle();
    rst = 1'b0;
    cycle();
    check_reset_outputs("midrst");
    bus.dbg_req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("final_dbg_ack", {63'd0, bus.dbg_ack}, 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
